// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// op encoding (funct3), controller states and special-case result constants.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, sharing one 64-bit working register.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    state_e              r_state;
    op_e                 r_op;
    logic [TAG_W-1:0]    r_tag;
    logic                r_sign_a;
    logic                r_sign_b;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opb;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_cnt;

    logic                w_sign_a;
    logic                w_sign_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_is_rem;
    logic                w_div0;
    logic                w_ovf;
    logic [XLEN-1:0]     w_special;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN+1:0]     w_diff;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quot;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_final;

    always_comb begin
        w_sign_a  = ((in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                     (in_op == OP_DIV)  || (in_op == OP_REM)) && in_a[XLEN-1];
        w_sign_b  = ((in_op == OP_MULH) || (in_op == OP_DIV) ||
                     (in_op == OP_REM)) && in_b[XLEN-1];
        w_mag_a   = w_sign_a ? (~in_a + 1'b1) : in_a;
        w_mag_b   = w_sign_b ? (~in_b + 1'b1) : in_b;
        w_is_rem  = in_op[2] & in_op[1];
        w_div0    = in_op[2] && (in_b == '0);
        w_ovf     = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                    (in_a == INT_MIN) && (in_b == '1);
        if (w_div0)
            w_special = w_is_rem ? in_a : DIV0_QUOT;
        else
            w_special = w_is_rem ? '0 : INT_MIN;
    end

    // Multiply step: conditionally add multiplicand to the upper half, shift right.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    end

    // Divide step: shift remainder:dividend left, keep the trial subtraction if no borrow.
    always_comb begin
        w_rem_sh = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff   = {1'b0, w_rem_sh} - {2'b00, r_opb};
        if (w_diff[XLEN+1])
            w_div_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        else
            w_div_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end

    always_comb begin
        w_prod = (r_sign_a ^ r_sign_b) ? (~w_mul_next + 1'b1) : w_mul_next;
        w_quot = (r_sign_a ^ r_sign_b) ? (~w_div_next[XLEN-1:0] + 1'b1)
                                       : w_div_next[XLEN-1:0];
        w_rem  = r_sign_a ? (~w_div_next[2*XLEN-1:XLEN] + 1'b1)
                          : w_div_next[2*XLEN-1:XLEN];
        case (r_op)
            OP_MUL:                     w_final = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                   w_final = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            w_final = w_quot;
            default:                    w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_MUL;
            r_tag    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else if (kill) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op     <= op_e'(in_op);
                        r_tag    <= in_tag;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_acc    <= {{XLEN{1'b0}}, w_mag_a};
                        r_opb    <= w_mag_b;
                        r_cnt    <= '0;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_special;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc <= r_op[2] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_result <= w_final;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE) && !kill;
    assign out_valid  = (r_state == ST_DONE);
    assign out_result = r_result;
    assign out_tag    = r_tag;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed vectors, latency, back-pressure,
// kill and asynchronous reset behaviour.
module tb_muldiv_unit;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op     = 3'd0;
    logic [31:0] in_a      = '0;
    logic [31:0] in_b      = '0;
    logic [4:0]  in_tag    = '0;
    logic        kill      = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .kill       (kill),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one request so it is accepted on the next rising edge; returns #1 after it.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] tag);
        @(negedge clk);
        check("in_ready before accept", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_op    = 3'($urandom_range(0, 7));
    endtask

    // Counts edges from the accept edge (edge 1) until out_valid is seen.
    task automatic wait_done(output int n);
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid after transfer", {31'b0, out_valid}, 32'd0);
        check("in_ready after transfer", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp, input int lat);
        int n;
        start_op(op, a, b, tag);
        wait_done(n);
        check({name, " latency"}, 32'(n), 32'(lat));
        check({name, " result"}, out_result, exp);
        check({name, " tag"}, {27'b0, out_tag}, {27'b0, tag});
        $display("%-8s a=%h b=%h -> %h tag=%0d after %0d edges", name, a, b, out_result, out_tag, n);
        release_result();
    endtask

    initial begin
        int n;
        #2;
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset out_result", out_result, 32'd0);
        check("reset out_tag", {27'b0, out_tag}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("MUL",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33);
        run_op("MULH",   3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33);
        run_op("MULHU",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 33);
        run_op("MULHSU", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 33);
        run_op("DIV",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33);
        run_op("REM",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33);
        run_op("DIVU",   3'd5, 32'd100,      32'd7,        5'd7,  32'd14,       33);
        run_op("REMU",   3'd7, 32'd100,      32'd7,        5'd8,  32'd2,        33);
        run_op("DIVnegB",3'd4, 32'd20,       32'hFFFFFFFA, 5'd9,  32'hFFFFFFFD, 33);
        run_op("REMnegB",3'd6, 32'd20,       32'hFFFFFFFA, 5'd10, 32'd2,        33);
        run_op("DIVU0",  3'd5, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1);
        run_op("REMU0",  3'd7, 32'd5,        32'd0,        5'd12, 32'd5,        1);
        run_op("DIVOVF", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1);
        run_op("REMOVF", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        1);

        // Back-pressure: result must hold while out_ready is low.
        start_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21);
        wait_done(n);
        check("bp latency", 32'(n), 32'd33);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp out_valid", {31'b0, out_valid}, 32'd1);
            check("bp result", out_result, 32'hFFFFFFFE);
            check("bp tag", {27'b0, out_tag}, 32'd21);
            check("bp in_ready", {31'b0, in_ready}, 32'd0);
        end
        $display("HOLD     result=%h tag=%0d held 10 cycles", out_result, out_tag);
        release_result();

        // Kill mid-calculation, with a simultaneous request that must be ignored.
        start_op(3'd5, 32'd100, 32'd7, 5'd22);
        repeat (15) @(posedge clk);
        @(negedge clk);
        kill     = 1'b1;
        in_valid = 1'b1;
        in_op    = 3'd5;
        in_a     = 32'd9;
        in_b     = 32'd3;
        in_tag   = 5'd23;
        @(posedge clk);
        #1;
        check("kill out_valid", {31'b0, out_valid}, 32'd0);
        check("kill in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("kill+valid out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        kill     = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post-kill idle", {31'b0, in_ready}, 32'd1);
        $display("KILL     in-flight DIVU discarded");
        run_op("DIVU9/3", 3'd5, 32'd9, 32'd3, 5'd24, 32'd3, 33);

        // Asynchronous reset mid-CALC.
        start_op(3'd4, 32'd20, 32'hFFFFFFFA, 5'd25);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst calc in_ready", {31'b0, in_ready}, 32'd1);
        check("rst calc out_valid", {31'b0, out_valid}, 32'd0);
        check("rst calc result", out_result, 32'd0);
        check("rst calc tag", {27'b0, out_tag}, 32'd0);
        $display("RESET    asserted mid-CALC");
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-DONE.
        start_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd26);
        wait_done(n);
        check("rst done pre result", out_result, 32'hFFFFFFFF);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst done out_valid", {31'b0, out_valid}, 32'd0);
        check("rst done result", out_result, 32'd0);
        check("rst done tag", {27'b0, out_tag}, 32'd0);
        $display("RESET    asserted mid-DONE");
        @(negedge clk);
        rst_n = 1'b1;
        run_op("MULpost", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd27, 32'hFFFFFFEB, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
